fifo_serial_reader: RTL and testbench
=====================================

// Module: fifo_serial_reader
// PURPOSE
//  Drain side of the 16x8 synchronous FIFO: pops one byte whenever the FIFO is non-empty and
//  serialises it on a UART-style 8N1 line (start bit 0, 8 data bits LSB first, stop bit 1).
//  Sits between the FIFO read port (re/data_out/empty) and the off-block serial pin. It is the
//  reader counterpart to the FIFO write path.
// PARAMETERS
//  DATA_W        8   byte width; must match the FIFO data width
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range >= 2
//  CNT_W         16  width of the sent-frame counter
// PORTS
//  clk         in   1       system clock; all state changes on the rising edge
//  rst         in   1       asynchronous, active-low reset (0 = reset)
//  enable      in   1       1 = drain the FIFO; 0 = finish the current frame, then stop popping
//  fifo_empty  in   1       FIFO empty flag
//  fifo_data   in   DATA_W  FIFO data_out; valid on the cycle after the edge that samples re=1
//  fifo_re     out  1       FIFO read enable; single-cycle pulse, registered
//  tx          out  1       serial output; idle level is 1
//  busy        out  1       1 from the POP state through the end of the STOP bit
//  frame_cnt   out  CNT_W   number of frames completed (stop bit finished)
// BEHAVIOUR
//  Reset (rst=0, asynchronous): state=IDLE, tx=1, fifo_re=0, busy=0, frame_cnt=0,
//   bit and baud counters cleared. A reset mid-frame drives tx to 1 immediately and drops the byte.
//  FSM states: IDLE, POP, WAIT, START, DATA, STOP. All outputs are registered or Moore.
//   IDLE : tx=1, busy=0. If enable && !fifo_empty at edge E, go to POP.
//   POP  : fifo_re=1 for exactly one cycle, then go to WAIT. busy=1.
//   WAIT : the FIFO has presented the byte. At the next edge, shreg<=fifo_data and go to START.
//   START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
//   DATA : tx=shreg[bit_idx] for CLKS_PER_BIT cycles per bit, LSB first. After bit DATA_W-1, go to STOP.
//   STOP : tx=1 for CLKS_PER_BIT cycles. On the final cycle, frame_cnt+=1, then:
//          if enable && !fifo_empty, go to POP (back-to-back); otherwise go to IDLE.
//  Latency: fifo_re is high in the cycle after edge E. tx falls at edge E+2.
//   A frame lasts (DATA_W+2)*CLKS_PER_BIT cycles.
//   Between back-to-back frames, tx stays high for 2 extra cycles (POP and WAIT).
//  Baud counter: counts 0..CLKS_PER_BIT-1 and advances the bit on terminal count.
//   It restarts at 0 on entry to START.
//  Handshake rules:
//   - fifo_re is never asserted while fifo_empty=1.
//   - Exactly one pop per frame.
//   - fifo_re is never asserted outside POP.
//   - fifo_empty is sampled only in IDLE and on the last STOP cycle.
//  enable falling mid-frame: the current frame completes unchanged, and no further pop occurs.
//   enable rising: takes effect at the next IDLE/STOP-end decision point.
//  FIFO becoming empty mid-frame has no effect on the frame in flight.
//   The block then goes to IDLE after STOP.
//  frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.
//  busy=1 in POP, WAIT, START, DATA and STOP.
// TESTING (CLKS_PER_BIT=4, DATA_W=8)
//  1 Reset: rst=0 mid-DATA bit -> tx=1, fifo_re=0, busy=0, frame_cnt=0 with no clk edge needed.
//    After release, the block stays in IDLE while fifo_empty=1.
//  2 Single byte: FIFO holds 8'hA5, enable=1 -> one fifo_re pulse.
//    tx sequence per 4 clks: 0,1,0,1,0,0,1,0,1,1. frame_cnt=1, then IDLE.
//  3 Burst: write 16 bytes 0..15, enable=1 -> exactly 16 fifo_re pulses, 16 frames in order.
//    Inter-frame tx-high gap is 4+2 cycles. frame_cnt=16; fifo_re stays 0 after empty.
//  4 enable dropped during bit 3 of 8'h3C with FIFO non-empty -> 8'h3C completes,
//    no further fifo_re, busy=0 after STOP. Re-enable -> next byte sent.
//  5 Empty guard: fifo_empty=1, enable toggling for 100 cycles -> fifo_re never 1, tx constant 1.
//  6 Wrap: CNT_W=4, send 17 frames -> frame_cnt reads 1.

Source files
------------

// File: rtl/fifo_serial_reader_if.sv
// FIFO read-port bundle between the FIFO and its serial drain block.
// The reader drives fifo_re; the FIFO drives the empty flag and the byte.
interface fifo_serial_reader_if #(
  parameter int DATA_W = 8
);
  logic              fifo_re;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  modport master (output fifo_re, input fifo_empty, input fifo_data);
  modport slave  (input fifo_re, output fifo_empty, output fifo_data);
endinterface

// File: rtl/fifo_serial_reader.sv
// FIFO drain: pops one byte per frame and shifts it out as 8N1 serial
// (start 0, data LSB first, stop 1), counting completed frames.
module fifo_serial_reader #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  fifo_serial_reader_if.master  fif,
  output logic                  tx,
  output logic                  busy,
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, POP, WAIT, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud;
  logic [BIT_W-1:0]    bit_idx;
  logic [DATA_W-1:0]   shreg;
  logic                fifo_re_q;
  logic                baud_tc, last_bit, go;

  assign baud_tc  = (baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_idx == BIT_W'(DATA_W - 1));
  // FIFO flag only matters at the two decision points: IDLE and last STOP cycle
  assign go       = enable && !fif.fifo_empty;
  assign fif.fifo_re = fifo_re_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (go) state_d = POP;
      POP:   state_d = WAIT;
      WAIT:  state_d = START;
      START: if (baud_tc) state_d = DATA;
      DATA:  if (baud_tc && last_bit) state_d = STOP;
      STOP:  if (baud_tc) state_d = go ? POP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state_q != IDLE);
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shreg[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  // Baud counter idles at 0 outside the serial states, so START always begins fresh
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      fifo_re_q <= 1'b0;
      frame_cnt <= '0;
    end else begin
      fifo_re_q <= (state_d == POP);
      if (state_q == START || state_q == DATA || state_q == STOP)
        baud <= baud_tc ? '0 : baud + 1'b1;
      else
        baud <= '0;
      if (state_q == START)
        bit_idx <= '0;
      else if (state_q == DATA && baud_tc)
        bit_idx <= bit_idx + 1'b1;
      if (state_q == WAIT)
        shreg <= fif.fifo_data;
      if (state_q == STOP && baud_tc)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Bench for fifo_serial_reader: FIFO model feeds the DUT, a line decoder
// pops expected bytes from a scoreboard queue; a CNT_W=4 twin checks wrap.
module tb_fifo_serial_reader;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic tx, busy, tx_w, busy_w;
  logic [15:0] frame_cnt;
  logic [3:0]  frame_cnt_w;

  fifo_serial_reader_if #(.DATA_W(8)) fif ();
  fifo_serial_reader_if #(.DATA_W(8)) fif_w ();

  fifo_serial_reader #(.DATA_W(8), .CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fif(fif),
    .tx(tx), .busy(busy), .frame_cnt(frame_cnt));

  fifo_serial_reader #(.DATA_W(8), .CLKS_PER_BIT(CPB), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .fif(fif_w),
    .tx(tx_w), .busy(busy_w), .frame_cnt(frame_cnt_w));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, pops = 0, lock_bad = 0;
  logic chk_gap = 1'b0;
  logic [7:0] exp_q[$];

  // FIFO model: registered data_out, valid the cycle after re is sampled
  logic [7:0] mem [0:255];
  int wr_cnt = 0, rd_cnt = 0;
  assign fif.fifo_empty   = (wr_cnt == rd_cnt);
  assign fif_w.fifo_empty = fif.fifo_empty;
  assign fif_w.fifo_data  = fif.fifo_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fif.fifo_re && rd_cnt != wr_cnt) begin
      fif.fifo_data <= mem[rd_cnt % 256];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_cnt % 256] = b;
    wr_cnt = wr_cnt + 1;
    exp_q.push_back(b);
  endtask

  // Handshake monitor: every pulse counted, checked against empty and width
  initial begin : pop_mon
    logic re_prev;
    re_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fif_w.fifo_re !== fif.fifo_re || tx_w !== tx || busy_w !== busy) lock_bad++;
      if (rst && fif.fifo_re) begin
        pops++;
        check("re_while_empty", fif.fifo_empty, 1'b0);
        check("re_single_cycle", re_prev, 1'b0);
      end
      re_prev = fif.fifo_re;
    end
  end

  // Line decoder: samples each bit mid-period, compares with scoreboard head
  initial begin : line_mon
    logic [7:0] b;
    logic ok;
    int prev_start, s;
    prev_start = -1;
    b = '0;
    forever begin
      @(negedge clk);
      if (rst && tx === 1'b0) begin
        s = cyc; ok = 1'b1;
        if (chk_gap) begin
          if (prev_start >= 0) check("frame_gap", s - prev_start, 42);
          prev_start = s;
        end else prev_start = -1;
        for (int k = 1; k <= 38; k++) begin
          @(negedge clk);
          if (!rst) ok = 1'b0;
          if (ok && k == 2) check("start_bit", tx, 1'b0);
          if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) b[(k - 6) / 4] = tx;
          if (ok && k == 38) check("stop_bit", tx, 1'b1);
        end
        if (ok) begin
          if (exp_q.size() == 0) check("unexpected_frame", b, 32'hFFFF_FFFF);
          else check("frame_byte", b, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_busy(input logic v, input int max, input string nm);
    int n = 0;
    while (busy !== v && n < max) begin @(negedge clk); n++; end
    check(nm, busy, v);
  endtask

  task automatic wait_tx_low(input int max, input string nm);
    int n = 0;
    while (tx !== 1'b0 && n < max) begin @(negedge clk); n++; end
    check(nm, tx, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : wdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p0, bad;
    // power-on reset
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_re", fif.fifo_re, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", frame_cnt, 16'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_empty_busy", busy, 1'b0);
    check("idle_empty_pops", pops, 0);

    // single byte with latency checks
    push(8'hA5); enable = 1'b1;
    @(negedge clk);
    check("lat_re_pulse", fif.fifo_re, 1'b1);
    check("lat_busy_pop", busy, 1'b1);
    @(negedge clk);
    check("lat_re_drop", fif.fifo_re, 1'b0);
    check("lat_tx_wait", tx, 1'b1);
    @(negedge clk);
    check("lat_tx_start", tx, 1'b0);
    wait_busy(1'b0, 60, "single_done");
    check("single_cnt", frame_cnt, 16'd1);
    check("single_pops", pops, 1);

    // reset mid-DATA (bit 2 of C3 is 0), no clock edge needed
    push(8'hC3);
    wait_tx_low(20, "mreset_start");
    repeat (13) @(negedge clk);
    check("mreset_pre_tx", tx, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("mreset_tx", tx, 1'b1);
    check("mreset_re", fif.fifo_re, 1'b0);
    check("mreset_busy", busy, 1'b0);
    check("mreset_cnt", frame_cnt, 16'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check("mreset_idle", busy, 1'b0);

    // burst of 16 back-to-back frames
    enable = 1'b0;
    do_reset();
    p0 = pops;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk_gap = 1'b1;
    enable = 1'b1;
    wait_busy(1'b1, 10, "burst_start");
    wait_busy(1'b0, 800, "burst_done");
    chk_gap = 1'b0;
    check("burst_cnt", frame_cnt, 16'd16);
    check("burst_pops", pops - p0, 16);
    repeat (20) @(negedge clk);
    check("burst_no_extra_re", pops - p0, 16);

    // enable dropped during bit 3
    enable = 1'b0;
    p0 = pops;
    push(8'h3C); push(8'h5A);
    enable = 1'b1;
    wait_tx_low(20, "drop_start");
    repeat (17) @(negedge clk);
    enable = 1'b0;
    wait_busy(1'b0, 60, "drop_done");
    check("drop_cnt", frame_cnt, 16'd17);
    repeat (20) @(negedge clk);
    check("drop_pops", pops - p0, 1);
    check("drop_busy", busy, 1'b0);
    enable = 1'b1;
    wait_busy(1'b1, 10, "reen_start");
    wait_busy(1'b0, 60, "reen_done");
    check("reen_cnt", frame_cnt, 16'd18);
    check("reen_pops", pops - p0, 2);

    // empty guard with toggling enable
    p0 = pops; bad = 0;
    for (int i = 0; i < 100; i++) begin
      enable = ~enable;
      @(negedge clk);
      if (tx !== 1'b1 || fif.fifo_re !== 1'b0) bad++;
    end
    check("empty_guard_bad", bad, 0);
    check("empty_guard_pops", pops - p0, 0);

    // counter wrap on the CNT_W=4 twin
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
    enable = 1'b1;
    wait_busy(1'b1, 10, "wrap_start");
    wait_busy(1'b0, 17 * 42 + 60, "wrap_done");
    check("wrap_cnt16", frame_cnt, 16'd17);
    check("wrap_cnt4", frame_cnt_w, 4'd1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("twin_lockstep", lock_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
